// File: rtl/synth_pkg.sv
// Shared definitions for the mono note allocator: priority mode codes,
// default widths, the stack entry layout and mode normalisation.
package synth_pkg;

    localparam logic [1:0] PRIO_LAST = 2'd0;
    localparam logic [1:0] PRIO_HIGH = 2'd1;
    localparam logic [1:0] PRIO_LOW  = 2'd2;

    localparam int NOTE_W_DEF = 7;
    localparam int VEL_W_DEF  = 7;

    typedef struct packed {
        logic                  valid;
        logic [NOTE_W_DEF-1:0] note;
        logic [VEL_W_DEF-1:0]  vel;
    } stack_entry_t;

    // Unused code 3 falls back to last-note priority.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            PRIO_HIGH: r = PRIO_HIGH;
            PRIO_LOW:  r = PRIO_LOW;
            default:   r = PRIO_LAST;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/note_stack.sv
// Arrival-ordered stack of held keys: search, insert, remove with compaction,
// oldest-entry eviction when full. Exposes the post-update (next) contents.
module note_stack #(
    parameter  int NOTE_W = 7,
    parameter  int VEL_W  = 7,
    parameter  int DEPTH  = 8,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    note_on,
    input  logic                    note_off,
    input  logic                    all_off,
    input  logic [NOTE_W-1:0]       note,
    input  logic [VEL_W-1:0]        velocity,
    output logic [DEPTH-1:0]        nxt_valid,
    output logic [DEPTH*NOTE_W-1:0] nxt_note,
    output logic [DEPTH*VEL_W-1:0]  nxt_vel,
    output logic [CW-1:0]           nxt_count,
    output logic [CW-1:0]           count
);

    logic [NOTE_W-1:0] note_r [DEPTH];
    logic [VEL_W-1:0]  vel_r  [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [CW-1:0]     count_r;

    logic [NOTE_W-1:0] note_s [DEPTH];
    logic [VEL_W-1:0]  vel_s  [DEPTH];
    logic [DEPTH-1:0]  valid_s;
    logic [CW-1:0]     cnt_s;
    logic              hit_s;
    logic [CW-1:0]     hit_idx_s;
    logic              rem_s;
    logic              add_s;
    logic [CW-1:0]     rem_idx_s;

    // Locate the strobed key among the valid entries (keys are unique).
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (note_r[i] == note)) begin
                hit_s     = 1'b1;
                hit_idx_s = CW'(i);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Decide which entry leaves the stack and whether a new one is appended.
    always_comb begin
        rem_s     = 1'b0;
        rem_idx_s = '0;
        add_s     = 1'b0;
        if (all_off) begin
            rem_s = 1'b0;
        end else if (note_on) begin
            add_s = 1'b1;
            if (hit_s) begin
                rem_s     = 1'b1;
                rem_idx_s = hit_idx_s;
            end else if (count_r == CW'(DEPTH)) begin
                rem_s     = 1'b1;
                rem_idx_s = '0;
            end else begin
                rem_s     = 1'b0;
            end
        end else if (note_off) begin
            rem_s     = hit_s;
            rem_idx_s = hit_idx_s;
        end else begin
            rem_s     = 1'b0;
        end
    end

    // Compact over the removed slot, append at the top, apply panic clear.
    always_comb begin
        cnt_s = rem_s ? (count_r - CW'(1)) : count_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (rem_s && (i >= int'(rem_idx_s))) begin
                note_s[i]  = note_r[(i < DEPTH - 1) ? i + 1 : i];
                vel_s[i]   = vel_r[(i < DEPTH - 1) ? i + 1 : i];
                valid_s[i] = (i < DEPTH - 1) ? valid_r[(i < DEPTH - 1) ? i + 1 : i] : 1'b0;
            end else begin
                note_s[i]  = note_r[i];
                vel_s[i]   = vel_r[i];
                valid_s[i] = valid_r[i];
            end
        end
        if (add_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(cnt_s)) begin
                    note_s[i]  = note;
                    vel_s[i]   = velocity;
                    valid_s[i] = 1'b1;
                end else begin
                    valid_s[i] = valid_s[i];
                end
            end
            cnt_s = cnt_s + CW'(1);
        end else begin
            cnt_s = cnt_s;
        end
        if (all_off) begin
            valid_s = '0;
            cnt_s   = '0;
        end else begin
            valid_s = valid_s;
        end
    end

    // Flatten the next-state view for the selector.
    always_comb begin
        nxt_note  = '0;
        nxt_vel   = '0;
        nxt_valid = valid_s;
        nxt_count = cnt_s;
        for (int i = 0; i < DEPTH; i++) begin
            nxt_note[i*NOTE_W +: NOTE_W] = note_s[i];
            nxt_vel[i*VEL_W +: VEL_W]    = vel_s[i];
        end
    end

    // Stack storage and key count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                note_r[i] <= '0;
                vel_r[i]  <= '0;
            end
        end else begin
            valid_r <= valid_s;
            count_r <= cnt_s;
            for (int i = 0; i < DEPTH; i++) begin
                note_r[i] <= note_s[i];
                vel_r[i]  <= vel_s[i];
            end
        end
    end

    assign count = count_r;

endmodule

// File: rtl/note_mono_prio.sv
// Monophonic note allocator: picks the sounding key from the held-key stack by
// last/highest/lowest priority and drives registered pitch, velocity, gate, retrig.
module note_mono_prio
    import synth_pkg::*;
#(
    parameter int NOTE_W = 7,
    parameter int VEL_W  = 7,
    parameter int DEPTH  = 8,
    parameter int LEGATO = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         note_on,
    input  logic                         note_off,
    input  logic [NOTE_W-1:0]            note,
    input  logic [VEL_W-1:0]             velocity,
    input  logic [1:0]                   mode,
    input  logic                         all_off,
    output logic [NOTE_W-1:0]            out_note,
    output logic [VEL_W-1:0]             out_vel,
    output logic                         out_gate,
    output logic                         out_retrig,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]        nxt_valid_s;
    logic [DEPTH*NOTE_W-1:0] nxt_note_s;
    logic [DEPTH*VEL_W-1:0]  nxt_vel_s;
    logic [CW-1:0]           nxt_count_s;
    logic [CW-1:0]           count_s;

    logic [1:0]              mode_s;
    logic [NOTE_W-1:0]       sel_note_s;
    logic [VEL_W-1:0]        sel_vel_s;
    logic                    gate_nxt_s;
    logic                    changed_s;
    logic                    retrig_nxt_s;

    logic [NOTE_W-1:0]       out_note_r;
    logic [VEL_W-1:0]        out_vel_r;
    logic                    out_gate_r;
    logic                    out_retrig_r;

    note_stack #(
        .NOTE_W (NOTE_W),
        .VEL_W  (VEL_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .note_on   (note_on),
        .note_off  (note_off),
        .all_off   (all_off),
        .note      (note),
        .velocity  (velocity),
        .nxt_valid (nxt_valid_s),
        .nxt_note  (nxt_note_s),
        .nxt_vel   (nxt_vel_s),
        .nxt_count (nxt_count_s),
        .count     (count_s)
    );

    // Priority selection over the post-update stack; valid entries start at 0.
    always_comb begin
        mode_s     = norm_mode(mode);
        sel_note_s = '0;
        sel_vel_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (nxt_valid_s[i]) begin
                case (mode_s)
                    PRIO_HIGH: begin
                        if ((i == 0) || (nxt_note_s[i*NOTE_W +: NOTE_W] > sel_note_s)) begin
                            sel_note_s = nxt_note_s[i*NOTE_W +: NOTE_W];
                            sel_vel_s  = nxt_vel_s[i*VEL_W +: VEL_W];
                        end else begin
                            sel_note_s = sel_note_s;
                        end
                    end
                    PRIO_LOW: begin
                        if ((i == 0) || (nxt_note_s[i*NOTE_W +: NOTE_W] < sel_note_s)) begin
                            sel_note_s = nxt_note_s[i*NOTE_W +: NOTE_W];
                            sel_vel_s  = nxt_vel_s[i*VEL_W +: VEL_W];
                        end else begin
                            sel_note_s = sel_note_s;
                        end
                    end
                    default: begin
                        sel_note_s = nxt_note_s[i*NOTE_W +: NOTE_W];
                        sel_vel_s  = nxt_vel_s[i*VEL_W +: VEL_W];
                    end
                endcase
            end else begin
                sel_note_s = sel_note_s;
            end
        end
    end

    // Retrigger on gate rise, or on a pitch/velocity change unless legato.
    always_comb begin
        gate_nxt_s   = (nxt_count_s != '0);
        changed_s    = (sel_note_s != out_note_r) || (sel_vel_s != out_vel_r);
        retrig_nxt_s = gate_nxt_s && (!out_gate_r || ((LEGATO == 0) && changed_s));
    end

    // Output registers; pitch and velocity hold through the release phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_note_r   <= '0;
            out_vel_r    <= '0;
            out_gate_r   <= 1'b0;
            out_retrig_r <= 1'b0;
        end else begin
            if (gate_nxt_s) begin
                out_note_r <= sel_note_s;
                out_vel_r  <= sel_vel_s;
            end else begin
                out_note_r <= out_note_r;
                out_vel_r  <= out_vel_r;
            end
            out_gate_r   <= gate_nxt_s;
            out_retrig_r <= retrig_nxt_s;
        end
    end

    assign out_note   = out_note_r;
    assign out_vel    = out_vel_r;
    assign out_gate   = out_gate_r;
    assign out_retrig = out_retrig_r;
    assign count      = count_s;

endmodule

// File: tb/tb_note_mono_prio.sv
// Directed bench for note_mono_prio: default build, a DEPTH=4 build and a
// LEGATO=1 build share one stimulus stream; each phase checks the relevant build.
module tb_note_mono_prio;

    logic       clk;
    logic       rst;
    logic       note_on;
    logic       note_off;
    logic       all_off;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [1:0] mode;

    logic [6:0] a_note, d_note, l_note;
    logic [6:0] a_vel,  d_vel,  l_vel;
    logic       a_gate, d_gate, l_gate;
    logic       a_rtg,  d_rtg,  l_rtg;
    logic [3:0] a_cnt;
    logic [2:0] d_cnt;
    logic [3:0] l_cnt;

    int n_cmp;
    int n_mis;

    note_mono_prio dut (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off), .note(note),
        .velocity(velocity), .mode(mode), .all_off(all_off), .out_note(a_note),
        .out_vel(a_vel), .out_gate(a_gate), .out_retrig(a_rtg), .count(a_cnt)
    );

    note_mono_prio #(.DEPTH(4)) dut_d4 (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off), .note(note),
        .velocity(velocity), .mode(mode), .all_off(all_off), .out_note(d_note),
        .out_vel(d_vel), .out_gate(d_gate), .out_retrig(d_rtg), .count(d_cnt)
    );

    note_mono_prio #(.LEGATO(1)) dut_leg (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off), .note(note),
        .velocity(velocity), .mode(mode), .all_off(all_off), .out_note(l_note),
        .out_vel(l_vel), .out_gate(l_gate), .out_retrig(l_rtg), .count(l_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag, input int en, input int ev, input int eg,
                              input int er, input int ec);
        check_val({tag, ".note"},   32'(a_note), 32'(en));
        check_val({tag, ".vel"},    32'(a_vel),  32'(ev));
        check_val({tag, ".gate"},   32'(a_gate), 32'(eg));
        check_val({tag, ".retrig"}, 32'(a_rtg),  32'(er));
        check_val({tag, ".count"},  32'(a_cnt),  32'(ec));
    endtask

    task automatic check_d4(input string tag, input int en, input int eg, input int er,
                            input int ec);
        check_val({tag, ".d4note"},   32'(d_note), 32'(en));
        check_val({tag, ".d4gate"},   32'(d_gate), 32'(eg));
        check_val({tag, ".d4retrig"}, 32'(d_rtg),  32'(er));
        check_val({tag, ".d4count"},  32'(d_cnt),  32'(ec));
    endtask

    // One cycle of strobes; returns 1 time unit after the capturing edge.
    task automatic do_ev(input logic on, input logic off, input logic pan,
                         input logic [6:0] n, input logic [6:0] v);
        @(negedge clk);
        note_on  = on;
        note_off = off;
        all_off  = pan;
        note     = n;
        velocity = v;
        @(posedge clk);
        #1;
        note_on  = 1'b0;
        note_off = 1'b0;
        all_off  = 1'b0;
    endtask

    task automatic idle();
        do_ev(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        note_on = 1'b0; note_off = 1'b0; all_off = 1'b0;
        note = 7'd0; velocity = 7'd0; mode = 2'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        check_main("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single onset
        do_ev(1'b1, 1'b0, 1'b0, 7'd60, 7'd100);
        check_main("on60", 60, 100, 1, 1, 1);
        idle();
        check_main("on60_hold", 60, 100, 1, 0, 1);

        // Last-note priority stack walk
        do_ev(1'b1, 1'b0, 1'b0, 7'd64, 7'd90);
        check_main("on64", 64, 90, 1, 1, 2);
        check_val("on64.leg_retrig", 32'(l_rtg), 32'd0);
        check_val("on64.leg_note", 32'(l_note), 32'd64);
        do_ev(1'b1, 1'b0, 1'b0, 7'd62, 7'd80);
        check_main("on62", 62, 80, 1, 1, 3);
        do_ev(1'b0, 1'b1, 1'b0, 7'd62, 7'd0);
        check_main("off62", 64, 90, 1, 1, 2);
        do_ev(1'b0, 1'b1, 1'b0, 7'd64, 7'd0);
        check_main("off64", 60, 100, 1, 1, 1);
        do_ev(1'b0, 1'b1, 1'b0, 7'd60, 7'd0);
        check_main("off60", 60, 100, 0, 0, 0);

        // Mode switching with 60, 67, 55 held
        do_ev(1'b1, 1'b0, 1'b0, 7'd60, 7'd10);
        do_ev(1'b1, 1'b0, 1'b0, 7'd67, 7'd20);
        do_ev(1'b1, 1'b0, 1'b0, 7'd55, 7'd30);
        check_main("held3", 55, 30, 1, 1, 3);
        mode = 2'd1;
        idle();
        check_main("mode_hi", 67, 20, 1, 1, 3);
        check_val("mode_hi.leg_note", 32'(l_note), 32'd67);
        check_val("mode_hi.leg_retrig", 32'(l_rtg), 32'd0);
        mode = 2'd2;
        idle();
        check_main("mode_lo", 55, 30, 1, 1, 3);
        check_val("mode_lo.leg_retrig", 32'(l_rtg), 32'd0);
        mode = 2'd1;
        idle();
        check_main("mode_hi2", 67, 20, 1, 1, 3);
        mode = 2'd3;
        idle();
        check_main("mode3", 55, 30, 1, 1, 3);
        mode = 2'd0;
        do_ev(1'b1, 1'b0, 1'b0, 7'd55, 7'd31);
        check_main("repress55", 55, 31, 1, 1, 3);
        do_ev(1'b1, 1'b0, 1'b0, 7'd60, 7'd11);
        check_main("repress60", 60, 11, 1, 1, 3);
        do_ev(1'b1, 1'b0, 1'b1, 7'd80, 7'd1);
        check_main("panic_on", 60, 11, 0, 0, 0);

        // note_on beats note_off in the same cycle; then panic with 3 held
        do_ev(1'b1, 1'b1, 1'b0, 7'd50, 7'd50);
        check_main("onoff50", 50, 50, 1, 1, 1);
        do_ev(1'b1, 1'b0, 1'b0, 7'd51, 7'd51);
        do_ev(1'b1, 1'b0, 1'b0, 7'd52, 7'd52);
        check_main("on52", 52, 52, 1, 1, 3);
        do_ev(1'b0, 1'b0, 1'b1, 7'd0, 7'd0);
        check_main("panic", 52, 52, 0, 0, 0);

        // DEPTH=4 eviction and compaction
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 10; k <= 14; k++) begin
            do_ev(1'b1, 1'b0, 1'b0, 7'(k), 7'(k));
        end
        check_d4("on14", 14, 1, 1, 4);
        check_main("on14", 14, 14, 1, 1, 5);
        do_ev(1'b0, 1'b1, 1'b0, 7'd10, 7'd0);
        check_d4("off10", 14, 1, 0, 4);
        check_main("off10", 14, 14, 1, 0, 4);
        do_ev(1'b0, 1'b1, 1'b0, 7'd14, 7'd0);
        check_d4("off14", 13, 1, 1, 3);
        do_ev(1'b0, 1'b1, 1'b0, 7'd11, 7'd0);
        check_d4("off11", 13, 1, 0, 2);
        do_ev(1'b0, 1'b1, 1'b0, 7'd12, 7'd0);
        check_d4("off12", 13, 1, 0, 1);
        do_ev(1'b0, 1'b1, 1'b0, 7'd13, 7'd0);
        check_d4("off13", 13, 0, 0, 0);
        check_main("off13", 13, 13, 0, 0, 0);

        // Asynchronous reset with keys held, then a clean onset
        do_ev(1'b1, 1'b0, 1'b0, 7'd1, 7'd1);
        do_ev(1'b1, 1'b0, 1'b0, 7'd2, 7'd2);
        do_ev(1'b1, 1'b0, 1'b0, 7'd3, 7'd3);
        check_main("pre_rst", 3, 3, 1, 1, 3);
        #2 rst = 1'b0;
        #1;
        check_main("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        do_ev(1'b1, 1'b0, 1'b0, 7'd70, 7'd70);
        check_main("on70", 70, 70, 1, 1, 1);
        idle();
        check_main("on70_hold", 70, 70, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
